pe_sequencer: RTL and testbench

//  Initiator side of the Processing_Element control/data interface. Accepts one job as a

---
 rtl/pe_seq_pkg.sv | 22 ++
 rtl/pe_sequencer_if.sv | 38 +++
 rtl/pe_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_pe_sequencer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_seq_pkg.sv
// Shared types for the PE sequencer: FSM state encoding and the job-length helper.
package pe_seq_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StClr,
      StLoadA,
      StGap,
      StLoadB,
      StMac,
      StRead,
      StOut
   } state_e;

   localparam int unsigned BeatW = 5;

   // Vector length per operand: 2, 4, 8 or 16 words.
   function automatic logic [BeatW-1:0] len_of(input logic [1:0] dimen);
      return 5'd2 << dimen;
   endfunction

endpackage

// File: rtl/pe_sequencer_if.sv
// Job stream, result stream and PE lane control/data pins of one sequencer instance.
interface pe_sequencer_if;

   logic        s_valid;
   logic        s_ready;
   logic [31:0] s_data;

   logic        m_valid;
   logic        m_ready;
   logic [31:0] m_data;

   logic        pe_rst_add;
   logic        pe_rst_acc;
   logic        pe_rst_pc;
   logic        pe_write_mat;
   logic        pe_mat_mux;
   logic [31:0] pe_datain;
   logic [1:0]  pe_dimen;
   logic        pe_mac_ctrl;
   logic        pe_out_ready;
   logic        pe_mac_done;
   logic [31:0] pe_dataout;

   modport master (
      input  s_valid, s_data, m_ready, pe_mac_done, pe_dataout,
      output s_ready, m_valid, m_data,
      output pe_rst_add, pe_rst_acc, pe_rst_pc, pe_write_mat, pe_mat_mux,
      output pe_datain, pe_dimen, pe_mac_ctrl, pe_out_ready
   );

   modport slave (
      output s_valid, s_data, m_ready, pe_mac_done, pe_dataout,
      input  s_ready, m_valid, m_data,
      input  pe_rst_add, pe_rst_acc, pe_rst_pc, pe_write_mat, pe_mat_mux,
      input  pe_datain, pe_dimen, pe_mac_ctrl, pe_out_ready
   );

endinterface

// File: rtl/pe_sequencer.sv
// Initiator for one PE lane: streams A then B into the PE, runs its MAC, returns the
// accumulator as a single result beat. Every PE-facing and result output is registered.
module pe_sequencer
   import pe_seq_pkg::*;
#(
   parameter int unsigned TMO_CYC = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [1:0]    cfg_dimen,
   output logic          busy,
   output logic          err_timeout,
   pe_sequencer_if.master bus
);

   localparam int unsigned TmoW = $clog2(TMO_CYC + 1);
   localparam logic [TmoW-1:0] TmoLast = TmoW'(TMO_CYC - 1);
   localparam logic [TmoW-1:0] TmoMax  = TmoW'(TMO_CYC);

   state_e            state_q, state_d;
   logic [BeatW-1:0]  beat_q, beat_d;
   logic [BeatW-1:0]  len_q, len_d;
   logic [TmoW-1:0]   tmo_q, tmo_d;
   logic              err_q, err_d;
   logic              s_ready_q, s_ready_d;
   logic              rst_add_q, rst_add_d;
   logic              rst_acc_q, rst_acc_d;
   logic              rst_pc_q, rst_pc_d;
   logic              write_q, write_d;
   logic              mux_q, mux_d;
   logic [31:0]       datain_q, datain_d;
   logic [1:0]        dimen_q, dimen_d;
   logic              mac_q, mac_d;
   logic              out_rdy_q, out_rdy_d;
   logic              m_valid_q, m_valid_d;
   logic [31:0]       m_data_q, m_data_d;

   logic              accept;
   logic              last_beat;

   assign accept    = bus.s_valid & s_ready_q;
   assign last_beat = (beat_q + 5'd1) == len_q;

   always_comb begin
      state_d   = state_q;
      beat_d    = beat_q;
      len_d     = len_q;
      tmo_d     = tmo_q;
      err_d     = err_q;
      s_ready_d = 1'b0;
      rst_add_d = 1'b0;
      rst_acc_d = 1'b0;
      rst_pc_d  = 1'b0;
      write_d   = 1'b0;
      mux_d     = mux_q;
      datain_d  = datain_q;
      dimen_d   = dimen_q;
      mac_d     = 1'b0;
      out_rdy_d = 1'b0;
      m_valid_d = 1'b0;
      m_data_d  = m_data_q;

      unique case (state_q)
         StIdle: begin
            if (bus.s_valid) begin
               dimen_d   = cfg_dimen;
               len_d     = len_of(cfg_dimen);
               rst_add_d = 1'b1;
               rst_acc_d = 1'b1;
               rst_pc_d  = 1'b1;
               state_d   = StClr;
            end
         end
         StClr: begin
            beat_d    = '0;
            tmo_d     = '0;
            mux_d     = 1'b1;
            s_ready_d = 1'b1;
            state_d   = StLoadA;
         end
         StLoadA: begin
            s_ready_d = 1'b1;
            mux_d     = 1'b1;
            if (accept) begin
               write_d  = 1'b1;
               datain_d = bus.s_data;
               beat_d   = beat_q + 5'd1;
               if (last_beat) begin
                  s_ready_d = 1'b0;
                  state_d   = StGap;
               end
            end
         end
         StGap: begin
            // The address reset lands one cycle after the final A write reaches the PE.
            beat_d    = '0;
            rst_add_d = 1'b1;
            mux_d     = 1'b0;
            s_ready_d = 1'b1;
            state_d   = StLoadB;
         end
         StLoadB: begin
            s_ready_d = 1'b1;
            mux_d     = 1'b0;
            if (accept) begin
               write_d  = 1'b1;
               datain_d = bus.s_data;
               beat_d   = beat_q + 5'd1;
               if (last_beat) begin
                  s_ready_d = 1'b0;
                  state_d   = StMac;
               end
            end
         end
         StMac: begin
            if (mac_q) begin
               tmo_d = (tmo_q == TmoMax) ? tmo_q : tmo_q + 1'b1;
               if (bus.pe_mac_done) begin
                  out_rdy_d = 1'b1;
                  state_d   = StRead;
               end else if (tmo_q >= TmoLast) begin
                  err_d   = 1'b1;
                  state_d = StIdle;
               end else begin
                  mac_d = 1'b1;
               end
            end else begin
               // First MAC cycle: the last B write is visible to the PE right now.
               mac_d = 1'b1;
            end
         end
         StRead: begin
            m_data_d  = bus.pe_dataout;
            m_valid_d = 1'b1;
            state_d   = StOut;
         end
         StOut: begin
            m_valid_d = 1'b1;
            if (m_valid_q && bus.m_ready) begin
               m_valid_d = 1'b0;
               state_d   = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         beat_q    <= '0;
         len_q     <= '0;
         tmo_q     <= '0;
         err_q     <= 1'b0;
         s_ready_q <= 1'b0;
         rst_add_q <= 1'b1;
         rst_acc_q <= 1'b1;
         rst_pc_q  <= 1'b1;
         write_q   <= 1'b0;
         mux_q     <= 1'b0;
         datain_q  <= '0;
         dimen_q   <= '0;
         mac_q     <= 1'b0;
         out_rdy_q <= 1'b0;
         m_valid_q <= 1'b0;
         m_data_q  <= '0;
      end else begin
         state_q   <= state_d;
         beat_q    <= beat_d;
         len_q     <= len_d;
         tmo_q     <= tmo_d;
         err_q     <= err_d;
         s_ready_q <= s_ready_d;
         rst_add_q <= rst_add_d;
         rst_acc_q <= rst_acc_d;
         rst_pc_q  <= rst_pc_d;
         write_q   <= write_d;
         mux_q     <= mux_d;
         datain_q  <= datain_d;
         dimen_q   <= dimen_d;
         mac_q     <= mac_d;
         out_rdy_q <= out_rdy_d;
         m_valid_q <= m_valid_d;
         m_data_q  <= m_data_d;
      end
   end

   assign busy             = (state_q != StIdle);
   assign err_timeout      = err_q;
   assign bus.s_ready      = s_ready_q;
   assign bus.m_valid      = m_valid_q;
   assign bus.m_data       = m_data_q;
   assign bus.pe_rst_add   = rst_add_q;
   assign bus.pe_rst_acc   = rst_acc_q;
   assign bus.pe_rst_pc    = rst_pc_q;
   assign bus.pe_write_mat = write_q;
   assign bus.pe_mat_mux   = mux_q;
   assign bus.pe_datain    = datain_q;
   assign bus.pe_dimen     = dimen_q;
   assign bus.pe_mac_ctrl  = mac_q;
   assign bus.pe_out_ready = out_rdy_q;

endmodule

// File: tb/tb_pe_sequencer.sv
// Bench for pe_sequencer: behavioural PE lane, dot-product scoreboard and pin-sequence counts.
module tb_pe_sequencer;

   localparam int unsigned TmoCyc = 32;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] cfg_dimen = 2'd0;
   logic       busy;
   logic       err_timeout;

   pe_sequencer_if bus();

   pe_sequencer #(.TMO_CYC(TmoCyc)) dut (
      .clk        (clk),
      .rst        (rst),
      .cfg_dimen  (cfg_dimen),
      .busy       (busy),
      .err_timeout(err_timeout),
      .bus        (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Behavioural PE lane: two operand memories, a write pointer, a MAC pointer, an accumulator.
   logic [31:0] pe_a[16];
   logic [31:0] pe_b[16];
   logic [4:0]  wr_ptr;
   logic [4:0]  mac_pc;
   logic [31:0] acc;
   logic [4:0]  pe_len;
   bit          hang = 1'b0;

   assign pe_len = 5'd2 << bus.pe_dimen;

   always @(posedge clk) begin
      if (bus.pe_rst_add) wr_ptr <= '0;
      else if (bus.pe_write_mat) wr_ptr <= wr_ptr + 5'd1;
      if (bus.pe_write_mat && !wr_ptr[4]) begin
         if (bus.pe_mat_mux) pe_a[wr_ptr[3:0]] <= bus.pe_datain;
         else pe_b[wr_ptr[3:0]] <= bus.pe_datain;
      end
      if (bus.pe_rst_acc) acc <= '0;
      else if (bus.pe_mac_ctrl && !mac_pc[4]) acc <= acc + pe_a[mac_pc[3:0]] * pe_b[mac_pc[3:0]];
      if (bus.pe_rst_pc) mac_pc <= '0;
      else if (bus.pe_mac_ctrl) mac_pc <= mac_pc + 5'd1;
   end

   assign bus.pe_mac_done = !hang && (mac_pc == pe_len - 5'd1);
   assign bus.pe_dataout  = bus.pe_out_ready ? acc : ~acc;

   // Pin activity counters.
   int wr_a_cnt = 0, wr_b_cnt = 0, gap_cnt = 0, gap_at_a = 0, gap_at_b = 0;
   int mac_cnt = 0, mvalid_cnt = 0, macc_cnt = 0, busy_drop = 0;
   bit watch_busy = 1'b0;

   always @(posedge clk) begin
      if (bus.pe_write_mat && bus.pe_mat_mux) wr_a_cnt <= wr_a_cnt + 1;
      if (bus.pe_write_mat && !bus.pe_mat_mux) wr_b_cnt <= wr_b_cnt + 1;
      if (bus.pe_rst_add && !bus.pe_rst_acc) begin
         gap_cnt  <= gap_cnt + 1;
         gap_at_a <= wr_a_cnt;
         gap_at_b <= wr_b_cnt;
      end
      if (bus.pe_mac_ctrl) mac_cnt <= mac_cnt + 1;
      if (bus.m_valid) mvalid_cnt <= mvalid_cnt + 1;
      if (bus.m_valid && bus.m_ready) macc_cnt <= macc_cnt + 1;
      if (watch_busy && !busy) busy_drop <= busy_drop + 1;
   end

   logic [31:0] ja[16];
   logic [31:0] jb[16];

   // Drives one job from a negedge and checks its outcome; returns on a negedge.
   task automatic run_job(input logic [1:0] dimen, input int gap_pct, input int hold,
                          input bit expect_tmo);
      int          n, idx, cyc, mism;
      int          b_wa, b_wb, b_gap, b_mac, b_mv, b_macc, b_drop;
      bit          acc_b;
      logic [31:0] exp_sum;
      logic [31:0] words[32];
      n = 2 << dimen;
      exp_sum = '0;
      for (int i = 0; i < n; i++) begin
         exp_sum      = exp_sum + ja[i] * jb[i];
         words[i]     = ja[i];
         words[n + i] = jb[i];
      end
      b_wa = wr_a_cnt; b_wb = wr_b_cnt; b_gap = gap_cnt; b_mac = mac_cnt;
      b_mv = mvalid_cnt; b_macc = macc_cnt; b_drop = busy_drop;
      cfg_dimen   = dimen;
      bus.m_ready = (hold == 0);
      idx = 0;
      cyc = 0;
      while (idx < 2 * n && cyc < 2000) begin
         bus.s_valid = ($urandom_range(99) >= gap_pct);
         bus.s_data  = words[idx];
         acc_b       = bus.s_valid && bus.s_ready;
         @(negedge clk);
         cyc++;
         if (acc_b) idx++;
         if (busy) watch_busy = 1'b1;
      end
      bus.s_valid = 1'b0;
      check("words_sent", idx, 2 * n);
      cyc = 0;
      while (!bus.m_valid && busy && cyc < 300) begin
         @(negedge clk);
         cyc++;
      end
      if (expect_tmo) begin
         watch_busy = 1'b0;
         check("tmo_mac_cycles", mac_cnt - b_mac, TmoCyc);
         check("tmo_err", err_timeout, 1'b1);
         check("tmo_no_result", mvalid_cnt - b_mv, 0);
         check("tmo_idle", busy, 1'b0);
      end else begin
         check("m_valid_seen", bus.m_valid, 1'b1);
         for (int k = 0; k < hold; k++) begin
            check("hold_valid", bus.m_valid, 1'b1);
            check("hold_data", bus.m_data, exp_sum);
            check("hold_s_ready", bus.s_ready, 1'b0);
            @(negedge clk);
         end
         bus.m_ready = 1'b1;
         check("result", bus.m_data, exp_sum);
         @(negedge clk);
         watch_busy = 1'b0;
         check("m_valid_drop", bus.m_valid, 1'b0);
         check("idle_after", busy, 1'b0);
         check("m_valid_beats", mvalid_cnt - b_mv, hold + 1);
         check("accepts", macc_cnt - b_macc, 1);
         check("writes_a", wr_a_cnt - b_wa, n);
         check("writes_b", wr_b_cnt - b_wb, n);
         check("gap_pulse", gap_cnt - b_gap, 1);
         check("gap_after_a", gap_at_a - b_wa, n);
         check("gap_before_b", gap_at_b - b_wb, 0);
         mism = 0;
         for (int i = 0; i < n; i++)
            if (pe_a[i] !== ja[i] || pe_b[i] !== jb[i]) mism++;
         check("pe_mem", mism, 0);
         check("busy_steady", busy_drop - b_drop, 0);
         check("pe_dimen", bus.pe_dimen, dimen);
      end
   endtask

   initial begin
      int cyc, b_wb, b_macc, b_mv;
      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      bus.m_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_pe_rst", {bus.pe_rst_add, bus.pe_rst_acc, bus.pe_rst_pc}, 3'b111);
      check("rst_ctrl", {bus.pe_write_mat, bus.pe_mat_mux, bus.pe_mac_ctrl, bus.pe_out_ready,
                         bus.m_valid, bus.s_ready, busy, err_timeout}, 8'd0);
      check("rst_datain", bus.pe_datain, 0);
      check("rst_m_data", bus.m_data, 0);
      rst = 1'b0;
      @(negedge clk);
      check("idle_pe_rst", {bus.pe_rst_add, bus.pe_rst_acc, bus.pe_rst_pc}, 3'b000);

      ja[0] = 3; ja[1] = 4; jb[0] = 5; jb[1] = 6;
      run_job(2'd0, 0, 0, 1'b0);
      check("t1_value", bus.m_data, 32'd39);

      for (int i = 0; i < 16; i++) begin
         ja[i] = i + 1;
         jb[i] = i + 1;
      end
      run_job(2'd3, 35, 0, 1'b0);
      check("t2_value", bus.m_data, 32'd1496);

      for (int i = 0; i < 4; i++) begin
         ja[i] = $urandom;
         jb[i] = $urandom;
      end
      run_job(2'd1, 20, 10, 1'b0);

      ja[0] = 32'hFFFF_FFFF; ja[1] = 0; jb[0] = 2; jb[1] = 0;
      run_job(2'd0, 0, 0, 1'b0);
      check("t6_value", bus.m_data, 32'hFFFF_FFFE);

      check("err_before_tmo", err_timeout, 1'b0);
      for (int i = 0; i < 16; i++) begin
         ja[i] = $urandom;
         jb[i] = $urandom;
      end
      hang = 1'b1;
      run_job(2'd2, 10, 0, 1'b1);
      hang = 1'b0;
      run_job(2'd2, 10, 0, 1'b0);
      check("err_sticky", err_timeout, 1'b1);

      for (int j = 0; j < 5; j++) begin
         for (int i = 0; i < 16; i++) begin
            ja[i] = $urandom;
            jb[i] = $urandom;
         end
         run_job(2'($urandom_range(3)), 30, int'($urandom_range(3)), 1'b0);
      end

      // Abort a job partway through the B vector.
      cfg_dimen   = 2'd2;
      bus.m_ready = 1'b1;
      b_wb   = wr_b_cnt;
      b_macc = macc_cnt;
      cyc    = 0;
      bus.s_valid = 1'b1;
      while (wr_b_cnt - b_wb < 2 && cyc < 200) begin
         bus.s_data = $urandom;
         @(negedge clk);
         cyc++;
      end
      check("t5_in_load_b", busy, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      check("t5_pe_rst", {bus.pe_rst_add, bus.pe_rst_acc, bus.pe_rst_pc}, 3'b111);
      check("t5_ctrl", {bus.pe_write_mat, bus.pe_mat_mux, bus.pe_mac_ctrl, bus.pe_out_ready,
                        bus.m_valid, bus.s_ready, busy, err_timeout}, 8'd0);
      check("t5_datain", bus.pe_datain, 0);
      rst = 1'b0;
      bus.s_valid = 1'b0;
      b_mv = mvalid_cnt;
      repeat (5) @(negedge clk);
      check("t5_no_result", (mvalid_cnt - b_mv) + (macc_cnt - b_macc), 0);
      ja[0] = 1; ja[1] = 2; ja[2] = 3; ja[3] = 4;
      jb[0] = 1; jb[1] = 1; jb[2] = 1; jb[3] = 1;
      run_job(2'd1, 25, 0, 1'b0);
      check("t5_value", bus.m_data, 32'd10);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
